// File: rtl/cart_bus_m_pkg.sv
// Shared definitions for the cartridge bus bridge: FSM state encoding,
// Game Boy address map boundaries and the address region decoder.
package cpu_defs;

   typedef enum logic [2:0] {
      RESET_HOLD = 3'd0,
      IDLE       = 3'd1,
      SETUP      = 3'd2,
      STROBE     = 3'd3,
      HOLD       = 3'd4
   } cart_state_e;

   typedef enum logic [1:0] {
      REGION_ROM  = 2'd0,
      REGION_RAM  = 2'd1,
      REGION_NONE = 2'd2
   } cart_region_e;

   localparam logic [15:0] CART_ROM_LO = 16'h0000;
   localparam logic [15:0] CART_ROM_HI = 16'h7FFF;
   localparam logic [15:0] CART_RAM_LO = 16'hA000;
   localparam logic [15:0] CART_RAM_HI = 16'hBFFF;

   // Offset-style range check keeps both bounds meaningful even when LO is zero.
   function automatic cart_region_e cart_decode(input logic [15:0] addr);
      logic [15:0] rom_off;
      logic [15:0] ram_off;
      rom_off = addr - CART_ROM_LO;
      ram_off = addr - CART_RAM_LO;
      if (rom_off <= (CART_ROM_HI - CART_ROM_LO)) begin
         return REGION_ROM;
      end else if (ram_off <= (CART_RAM_HI - CART_RAM_LO)) begin
         return REGION_RAM;
      end else begin
         return REGION_NONE;
      end
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/cart_bus_m_if.sv
// MMU-side request/response channel of the cartridge bridge.
interface cart_bus_m_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;

   modport master (
      output req_valid,
      output req_we,
      output req_addr,
      output req_wdata,
      input  req_ready,
      input  rsp_valid,
      input  rsp_rdata
   );

   modport slave (
      input  req_valid,
      input  req_we,
      input  req_addr,
      input  req_wdata,
      output req_ready,
      output rsp_valid,
      output rsp_rdata
   );

endinterface

// File: rtl/cart_bus_m_clk_div.sv
// Free-running cartridge PHI divider. Held low while disabled, so the
// cartridge sees no clock edges while it is in reset.
module cart_clk_div_m #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic cart_clk_o
);

   localparam int HALF  = CLK_DIV / 2;
   localparam int CW    = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);

   logic [CW-1:0] cnt_q;
   logic          clk_q;

   // Down-count half periods; toggle the output on terminal count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= HALF_LD;
         clk_q <= 1'b0;
      end else if (!en_i) begin
         cnt_q <= HALF_LD;
         clk_q <= 1'b0;
      end else if (cnt_q == '0) begin
         cnt_q <= HALF_LD;
         clk_q <= ~clk_q;
      end else begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign cart_clk_o = clk_q;

endmodule

// File: rtl/cart_bus_m.sv
// Cartridge bus bridge: turns MMU request/response transfers into timed
// cartridge edge-connector cycles, and sequences cartridge reset and PHI.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RESET_HOLD | cart_n_rst low for RST_CYC cycles, no requests accepted
// IDLE       | req_ready high, waiting for an MMU access
// SETUP      | address / chip select settling before the strobe
// STROBE     | n_rd or n_wr low; read data sampled on the exit edge
// HOLD       | strobes high, address and data held; response on exit
module cart_bus_m
   import cpu_defs::*;
#(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1,
   parameter int RST_CYC    = 16,
   parameter int CLK_DIV    = 4
) (
   input  logic        clk,
   input  logic        rst,
   cart_bus_m_if.slave bus,
   output logic        cart_clk,
   output logic        cart_n_rst,
   output logic        cart_n_cs,
   output logic        cart_n_rd,
   output logic        cart_n_wr,
   output logic [15:0] cart_addr,
   output logic [7:0]  cart_data_out,
   output logic        cart_data_oe,
   input  logic [7:0]  cart_data_in
);

   localparam logic [2:0] S_RESET_HOLD = RESET_HOLD;
   localparam logic [2:0] S_IDLE       = IDLE;
   localparam logic [2:0] S_SETUP      = SETUP;
   localparam logic [2:0] S_STROBE     = STROBE;
   localparam logic [2:0] S_HOLD       = HOLD;

   // One shared down-counter; loads hold (cycles - 1) so 0 is the last cycle.
   localparam int CNT_MAX = max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, RST_CYC);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYC - 1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             we_q, we_d;
   cart_region_e     region_q, region_d;
   logic             ready_q, ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             n_rst_q, n_rst_d;
   logic             n_cs_q, n_cs_d;
   logic             n_rd_q, n_rd_d;
   logic             n_wr_q, n_wr_d;
   logic [15:0]      addr_q, addr_d;
   logic [7:0]       dout_q, dout_d;
   logic             oe_q, oe_d;

   logic             accept;
   logic             cnt_done;
   cart_region_e     req_region;

   // ready_q is only ever high in IDLE, so it doubles as the state qualifier.
   assign accept     = bus.req_valid && ready_q;
   assign cnt_done   = (cnt_q == '0);
   assign req_region = cart_decode(bus.req_addr);

   // Next-state and next-output computation for the access sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      region_d    = region_q;
      ready_d     = ready_q;
      rsp_valid_d = 1'b0;
      rdata_d     = rdata_q;
      n_rst_d     = n_rst_q;
      n_cs_d      = n_cs_q;
      n_rd_d      = n_rd_q;
      n_wr_d      = n_wr_q;
      addr_d      = addr_q;
      dout_d      = dout_q;
      oe_d        = oe_q;

      case (state_q)
         S_RESET_HOLD: begin
            if (cnt_done) begin
               state_d = S_IDLE;
               n_rst_d = 1'b1;
               ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_IDLE: begin
            if (accept) begin
               state_d  = S_SETUP;
               cnt_d    = SETUP_LD;
               ready_d  = 1'b0;
               we_d     = bus.req_we;
               region_d = req_region;
               addr_d   = bus.req_addr;
               n_cs_d   = (req_region != REGION_RAM);
               if (bus.req_we && (req_region != REGION_NONE)) begin
                  oe_d   = 1'b1;
                  dout_d = bus.req_wdata;
               end
            end
         end

         S_SETUP: begin
            if (cnt_done) begin
               state_d = S_STROBE;
               cnt_d   = STROBE_LD;
               // Unmapped addresses run the same timing with no strobe.
               if (region_q != REGION_NONE) begin
                  n_rd_d = we_q;
                  n_wr_d = !we_q;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_STROBE: begin
            if (cnt_done) begin
               state_d = S_HOLD;
               cnt_d   = HOLD_LD;
               n_rd_d  = 1'b1;
               n_wr_d  = 1'b1;
               if (!we_q) begin
                  rdata_d = (region_q == REGION_NONE) ? 8'hFF : cart_data_in;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_HOLD: begin
            if (cnt_done) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b1;
               ready_d     = 1'b1;
               n_cs_d      = 1'b1;
               oe_d        = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = S_RESET_HOLD;
            cnt_d   = RST_LD;
            ready_d = 1'b0;
            n_rst_d = 1'b0;
            n_cs_d  = 1'b1;
            n_rd_d  = 1'b1;
            n_wr_d  = 1'b1;
            oe_d    = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_RESET_HOLD;
         cnt_q       <= RST_LD;
         we_q        <= 1'b0;
         region_q    <= REGION_NONE;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 8'hFF;
         n_rst_q     <= 1'b0;
         n_cs_q      <= 1'b1;
         n_rd_q      <= 1'b1;
         n_wr_q      <= 1'b1;
         addr_q      <= 16'h0000;
         dout_q      <= 8'h00;
         oe_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         region_q    <= region_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         n_rst_q     <= n_rst_d;
         n_cs_q      <= n_cs_d;
         n_rd_q      <= n_rd_d;
         n_wr_q      <= n_wr_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         oe_q        <= oe_d;
      end
   end

   cart_clk_div_m #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk        (clk),
      .rst        (rst),
      .en_i       (n_rst_q),
      .cart_clk_o (cart_clk)
   );

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign cart_n_rst    = n_rst_q;
   assign cart_n_cs     = n_cs_q;
   assign cart_n_rd     = n_rd_q;
   assign cart_n_wr     = n_wr_q;
   assign cart_addr     = addr_q;
   assign cart_data_out = dout_q;
   assign cart_data_oe  = oe_q;

   // Bus-contention and address-stability invariants on the cartridge pins.
   a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
      !(!n_rd_q && !n_wr_q));
   a_oe_vs_rd: assert property (@(posedge clk) disable iff (rst)
      !(oe_q && !n_rd_q));
   a_addr_stable: assert property (@(posedge clk) disable iff (rst)
      (!n_rd_q || !n_wr_q) |=> ((n_rd_q && n_wr_q) || $stable(addr_q)));

endmodule

// File: tb/tb_cart_bus_m.sv
// Directed bench for the cartridge bus bridge with a simple cartridge model.
module tb_cart_bus_m;

   logic        clk;
   logic        rst;
   logic        cart_clk;
   logic        cart_n_rst;
   logic        cart_n_cs;
   logic        cart_n_rd;
   logic        cart_n_wr;
   logic [15:0] cart_addr;
   logic [7:0]  cart_data_out;
   logic        cart_data_oe;
   wire  [7:0]  cart_data_in;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int rsp_cnt = 0;

   cart_bus_m_if bus ();

   cart_bus_m dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .cart_clk      (cart_clk),
      .cart_n_rst    (cart_n_rst),
      .cart_n_cs     (cart_n_cs),
      .cart_n_rd     (cart_n_rd),
      .cart_n_wr     (cart_n_wr),
      .cart_addr     (cart_addr),
      .cart_data_out (cart_data_out),
      .cart_data_oe  (cart_data_oe),
      .cart_data_in  (cart_data_in)
   );

   // Cartridge model: header byte at 0x0147 is 0x1B, otherwise low byte ^ 0x5A.
   assign cart_data_in = (cart_addr == 16'h0147) ? 8'h1B : (cart_addr[7:0] ^ 8'h5A);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pin invariants, sampled every negedge while out of reset.
   logic        prev_strobe = 1'b0;
   logic [15:0] prev_addr   = 16'h0;
   always @(negedge clk) begin
      if (bus.rsp_valid === 1'b1) rsp_cnt++;
      if (!rst) begin
         if (!cart_n_rd || !cart_n_wr) begin
            chk("strobe_exclusive", {cart_n_rd, cart_n_wr} != 2'b00, 1);
            chk("oe_vs_rd", cart_data_oe && !cart_n_rd, 0);
            if (prev_strobe) chk("addr_stable", cart_addr, prev_addr);
         end
      end
      prev_strobe = !rst && (!cart_n_rd || !cart_n_wr);
      prev_addr   = cart_addr;
   end

   // Trace of one access: index i is sampled on the negedge after accept+i.
   logic [4:0]  tr_rd, tr_wr, tr_cs, tr_oe, tr_rv;
   logic [15:0] tr_addr;
   logic [7:0]  tr_dout;

   task automatic access(input logic we, input logic [15:0] a, input logic [7:0] d);
      int waited;
      waited = 0;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_valid = 1'b1;
      while (bus.req_ready !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      chk("accept_in_time", waited < 40, 1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tr_rd[i] = cart_n_rd;
         tr_wr[i] = cart_n_wr;
         tr_cs[i] = cart_n_cs;
         tr_oe[i] = cart_data_oe;
         tr_rv[i] = bus.rsp_valid;
         if (i == 0) begin
            tr_addr = cart_addr;
            tr_dout = cart_data_out;
         end
      end
   endtask

   logic [5:0] clk_tr;
   logic [7:0] exp_b2b [3] = '{8'h5A, 8'h5B, 8'h58};
   int         lo_cnt;
   int         waited;
   int         prev_cyc;
   int         rsp_base;

   initial begin
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 16'h0;
      bus.req_wdata = 8'h0;
      repeat (3) @(negedge clk);

      chk("rst_n_rst",  cart_n_rst, 0);
      chk("rst_n_cs",   cart_n_cs, 1);
      chk("rst_n_rd",   cart_n_rd, 1);
      chk("rst_n_wr",   cart_n_wr, 1);
      chk("rst_addr",   cart_addr, 16'h0000);
      chk("rst_dout",   cart_data_out, 8'h00);
      chk("rst_oe",     cart_data_oe, 0);
      chk("rst_ready",  bus.req_ready, 0);
      chk("rst_rsp",    bus.rsp_valid, 0);
      chk("rst_rdata",  bus.rsp_rdata, 8'hFF);
      chk("rst_cclk",   cart_clk, 0);

      // Reset release: 16 cycles of cart reset, ready on cycle 17.
      @(posedge clk);
      #1 rst = 1'b0;
      lo_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (cart_n_rst === 1'b0 && bus.req_ready === 1'b0 && cart_clk === 1'b0) lo_cnt++;
      end
      @(negedge clk);
      chk("rst_hold_cycles", lo_cnt, 16);
      chk("n_rst_released", cart_n_rst, 1);
      chk("ready_cycle17", bus.req_ready, 1);
      chk("cclk_at_release", cart_clk, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         clk_tr[i] = cart_clk;
      end
      chk("cclk_pattern", clk_tr, 6'b100110);

      // ROM read of the cartridge header type byte.
      access(1'b0, 16'h0147, 8'h00);
      chk("rd0147_n_rd",  tr_rd, 5'b11001);
      chk("rd0147_n_wr",  tr_wr, 5'b11111);
      chk("rd0147_n_cs",  tr_cs, 5'b11111);
      chk("rd0147_oe",    tr_oe, 5'b00000);
      chk("rd0147_rsp",   tr_rv, 5'b10000);
      chk("rd0147_addr",  tr_addr, 16'h0147);
      chk("rd0147_rdata", bus.rsp_rdata, 8'h1B);

      // MBC register write.
      access(1'b1, 16'h2000, 8'h05);
      chk("wr2000_n_wr", tr_wr, 5'b11001);
      chk("wr2000_n_rd", tr_rd, 5'b11111);
      chk("wr2000_n_cs", tr_cs, 5'b11111);
      chk("wr2000_oe",   tr_oe, 5'b01111);
      chk("wr2000_dout", tr_dout, 8'h05);
      chk("wr2000_rsp",  tr_rv, 5'b10000);

      // External RAM read.
      access(1'b0, 16'hA010, 8'h00);
      chk("rdA010_n_cs",  tr_cs, 5'b10000);
      chk("rdA010_n_rd",  tr_rd, 5'b11001);
      chk("rdA010_rsp",   tr_rv, 5'b10000);
      chk("rdA010_rdata", bus.rsp_rdata, 8'h4A);

      // Three back-to-back reads with req_valid held high.
      bus.req_we    = 1'b0;
      bus.req_addr  = 16'h0100;
      bus.req_valid = 1'b1;
      prev_cyc      = 0;
      for (int k = 0; k < 3; k++) begin
         waited = 0;
         while (bus.req_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
         end
         chk("b2b_accept_in_time", waited < 40, 1);
         if (k > 0) begin
            chk("b2b_rsp_on_accept", bus.rsp_valid, 1);
            chk("b2b_rdata", bus.rsp_rdata, exp_b2b[k-1]);
         end
         @(posedge clk);
         #1;
         if (k > 0) chk("b2b_period", cyc - prev_cyc, 5);
         prev_cyc     = cyc;
         bus.req_addr = 16'h0101 + 16'(k);
         if (k == 2) bus.req_valid = 1'b0;
      end
      waited = 0;
      while (bus.rsp_valid !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      chk("b2b_last_rsp_in_time", waited < 40, 1);
      chk("b2b_last_rdata", bus.rsp_rdata, 8'h58);
      @(negedge clk);

      // Unmapped read: no strobe, 0xFF returned at normal latency.
      access(1'b0, 16'hC000, 8'h00);
      chk("rdC000_n_rd",  tr_rd, 5'b11111);
      chk("rdC000_n_wr",  tr_wr, 5'b11111);
      chk("rdC000_n_cs",  tr_cs, 5'b11111);
      chk("rdC000_oe",    tr_oe, 5'b00000);
      chk("rdC000_rsp",   tr_rv, 5'b10000);
      chk("rdC000_rdata", bus.rsp_rdata, 8'hFF);

      // Unmapped write: dropped, still acknowledged.
      access(1'b1, 16'h9000, 8'h33);
      chk("wr9000_n_wr", tr_wr, 5'b11111);
      chk("wr9000_n_rd", tr_rd, 5'b11111);
      chk("wr9000_n_cs", tr_cs, 5'b11111);
      chk("wr9000_oe",   tr_oe, 5'b00000);
      chk("wr9000_rsp",  tr_rv, 5'b10000);
      chk("wr9000_rdata", bus.rsp_rdata, 8'hFF);

      // Reset asserted in the middle of a write strobe.
      bus.req_we    = 1'b1;
      bus.req_addr  = 16'h2000;
      bus.req_wdata = 8'h77;
      bus.req_valid = 1'b1;
      waited = 0;
      while (bus.req_ready !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      chk("midrst_accept_in_time", waited < 40, 1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_in_strobe_n_wr", cart_n_wr, 0);
      chk("midrst_in_strobe_oe", cart_data_oe, 1);
      rsp_base = rsp_cnt;
      #2 rst = 1'b1;
      #1;
      chk("midrst_n_wr_async", cart_n_wr, 1);
      chk("midrst_oe_async", cart_data_oe, 0);
      chk("midrst_n_rst_async", cart_n_rst, 0);
      chk("midrst_ready_async", bus.req_ready, 0);
      chk("midrst_addr_async", cart_addr, 16'h0000);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      lo_cnt = 0;
      while (cart_n_rst !== 1'b1 && lo_cnt < 40) begin
         @(negedge clk);
         if (cart_n_rst === 1'b0) lo_cnt++;
      end
      chk("midrst_replay_cycles", lo_cnt, 16);
      chk("midrst_no_rsp", rsp_cnt - rsp_base, 0);
      chk("midrst_ready_after", bus.req_ready, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
